// File: rtl/dm_pkg.sv
// dm_pkg: access codes and FSM states shared by the data-memory access unit
package dm_pkg;

    typedef enum logic [2:0] {
        DM_RD_NONE = 3'd0,
        LB         = 3'd1,
        LH         = 3'd2,
        LW         = 3'd3,
        LBU        = 3'd4,
        LHU        = 3'd5
    } dm_rd_e;

    typedef enum logic [1:0] {
        DM_WR_NONE = 2'd0,
        SB         = 2'd1,
        SH         = 2'd2,
        SW         = 2'd3
    } dm_wr_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } dm_state_e;

endpackage

// File: rtl/dm_access_unit_align.sv
// dm_lane_align: byte-lane placement for stores, extraction/extension for loads, misalignment detect
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [2:0]  i_rd,
    input  logic [1:0]  i_wr,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_rs2,
    input  logic [2:0]  i_ld_code,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rdata,
    output logic        o_access,
    output logic        o_store,
    output logic        o_misaligned,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load
);

    logic        w_load;
    logic        w_half;
    logic        w_word;
    logic [31:0] w_shift;

    // Decode the effective access; a store always takes precedence over a load
    always_comb begin
        o_store      = i_wr != DM_WR_NONE;
        w_load       = !o_store && i_rd != DM_RD_NONE && i_rd <= LHU;
        o_access     = o_store || w_load;
        w_half       = o_store ? i_wr == SH : w_load && (i_rd == LH || i_rd == LHU);
        w_word       = o_store ? i_wr == SW : w_load && i_rd == LW;
        o_misaligned = (w_half && i_off[0]) || (w_word && i_off != 2'd0);
    end

    // Place store strobes and replicated data on the lanes selected by the offset
    always_comb begin
        o_wstrb = i_wr == SB ? 4'b0001 << i_off :
                  i_wr == SH ? 4'b0011 << i_off :
                  i_wr == SW ? 4'hF : 4'h0;
        o_wdata = i_wr == SB ? {4{i_rs2[7:0]}} :
                  i_wr == SH ? {2{i_rs2[15:0]}} :
                  i_wr == SW ? i_rs2 : 32'd0;
    end

    // Shift the addressed bytes down and extend per the captured load code
    always_comb begin
        w_shift = i_rdata >> {i_ld_off, 3'b000};
        o_load  = i_ld_code == LB  ? {{24{w_shift[7]}}, w_shift[7:0]} :
                  i_ld_code == LH  ? {{16{w_shift[15]}}, w_shift[15:0]} :
                  i_ld_code == LBU ? {24'd0, w_shift[7:0]} :
                  i_ld_code == LHU ? {16'd0, w_shift[15:0]} :
                  i_ld_code == LW  ? w_shift : 32'd0;
    end

endmodule

// File: rtl/dm_access_unit.sv
// dm_access_unit: MEM-stage data-memory access FSM with pipeline stall control
module dm_access_unit
    import dm_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        i_DM_read,
    input  logic [1:0]        i_DM_write,
    input  logic [ADDR_W-1:0] i_aluresult,
    input  logic [DATA_W-1:0] i_rs2_data,
    input  logic              i_wait_WFI,
    output logic              o_wait_DM1,
    output logic [DATA_W-1:0] o_load_data,
    output logic              o_misaligned,
    output logic              o_dm_req,
    output logic              o_dm_we,
    output logic [ADDR_W-1:0] o_dm_addr,
    output logic [3:0]        o_dm_wstrb,
    output logic [DATA_W-1:0] o_dm_wdata,
    input  logic              i_dm_gnt,
    input  logic              i_dm_rvalid,
    input  logic [DATA_W-1:0] i_dm_rdata
);

    dm_state_e         r_state;
    dm_state_e         w_next;
    logic              w_access;
    logic              w_store;
    logic              w_mis;
    logic              w_start;
    logic [3:0]        w_wstrb;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_load;
    logic [2:0]        r_ld_code;
    logic [1:0]        r_ld_off;
    logic              r_we;
    logic [3:0]        r_wstrb;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_load_data;
    logic              r_misaligned;

    dm_lane_align u_align (
        .i_rd        (i_DM_read),
        .i_wr        (i_DM_write),
        .i_off       (i_aluresult[1:0]),
        .i_rs2       (i_rs2_data),
        .i_ld_code   (r_ld_code),
        .i_ld_off    (r_ld_off),
        .i_rdata     (i_dm_rdata),
        .o_access    (w_access),
        .o_store     (w_store),
        .o_misaligned(w_mis),
        .o_wstrb     (w_wstrb),
        .o_wdata     (w_wdata),
        .o_load      (w_load)
    );

    assign w_start      = r_state == S_IDLE && w_access;
    assign o_dm_we      = r_we;
    assign o_dm_addr    = r_addr;
    assign o_dm_wstrb   = r_wstrb;
    assign o_dm_wdata   = r_wdata;
    assign o_load_data  = r_load_data;
    assign o_misaligned = r_misaligned;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state, bus request and pipeline stall
    always_comb begin
        w_next     = r_state;
        o_dm_req   = r_state == S_REQ;
        o_wait_DM1 = w_start || r_state == S_REQ || r_state == S_RESP;
        case (r_state)
            S_IDLE:  w_next = !w_access ? S_IDLE : w_mis ? S_DONE : S_REQ;
            S_REQ:   w_next = i_dm_gnt ? S_RESP : S_REQ;
            S_RESP:  w_next = i_dm_rvalid ? S_DONE : S_RESP;
            default: w_next = i_wait_WFI ? S_DONE : S_IDLE;
        endcase
    end

    // Capture request fields at issue, pulse misalignment, capture load results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wstrb      <= 4'h0;
            r_wdata      <= '0;
            r_ld_code    <= 3'd0;
            r_ld_off     <= 2'd0;
            r_load_data  <= '0;
            r_misaligned <= 1'b0;
        end else begin
            if (w_start && !w_mis) begin
                r_addr    <= {i_aluresult[ADDR_W-1:2], 2'b00};
                r_we      <= w_store;
                r_wstrb   <= w_wstrb;
                r_wdata   <= w_wdata;
                r_ld_code <= w_store ? 3'd0 : i_DM_read;
                r_ld_off  <= i_aluresult[1:0];
            end
            r_misaligned <= w_start && w_mis;
            if (w_start && w_mis && !w_store)
                r_load_data <= '0;
            else if (r_state == S_RESP && i_dm_rvalid && r_ld_code != 3'd0)
                r_load_data <= w_load;
        end
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// tb_dm_access_unit: scoreboard bench for the data-memory access unit
module tb_dm_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  i_DM_read = 3'd0;
    logic [1:0]  i_DM_write = 2'd0;
    logic [31:0] i_aluresult = 32'd0;
    logic [31:0] i_rs2_data = 32'd0;
    logic        i_wait_WFI = 1'b0;
    logic        o_wait_DM1;
    logic [31:0] o_load_data;
    logic        o_misaligned;
    logic        o_dm_req;
    logic        o_dm_we;
    logic [31:0] o_dm_addr;
    logic [3:0]  o_dm_wstrb;
    logic [31:0] o_dm_wdata;
    logic        i_dm_gnt = 1'b0;
    logic        i_dm_rvalid = 1'b0;
    logic [31:0] i_dm_rdata = 32'd0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          reqc;
    } bus_t;

    typedef struct {
        logic [31:0] ld;
        logic        mis;
        int          stall;
    } done_t;

    bus_t        bus_q[$];
    done_t       done_q[$];
    int          tests = 0;
    int          fails = 0;
    int          nreq = 0;
    int          exp_req = 0;
    int          gnt_dly = 0;
    int          rv_dly = 1;
    logic        inj = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    dm_access_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_DM_read   (i_DM_read),
        .i_DM_write  (i_DM_write),
        .i_aluresult (i_aluresult),
        .i_rs2_data  (i_rs2_data),
        .i_wait_WFI  (i_wait_WFI),
        .o_wait_DM1  (o_wait_DM1),
        .o_load_data (o_load_data),
        .o_misaligned(o_misaligned),
        .o_dm_req    (o_dm_req),
        .o_dm_we     (o_dm_we),
        .o_dm_addr   (o_dm_addr),
        .o_dm_wstrb  (o_dm_wstrb),
        .o_dm_wdata  (o_dm_wdata),
        .i_dm_gnt    (i_dm_gnt),
        .i_dm_rvalid (i_dm_rvalid),
        .i_dm_rdata  (i_dm_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Memory responder: grant after gnt_dly request cycles, respond rv_dly cycles after grant
    initial begin
        int   rc;
        int   pc;
        logic pend;
        logic pg;
        rc = 0; pc = 0; pend = 1'b0; pg = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            i_dm_gnt    = 1'b0;
            i_dm_rvalid = 1'b0;
            i_dm_rdata  = mem_rdata;
            if (!rst_n) begin
                pend = 1'b0; pg = 1'b0; rc = 0;
            end else begin
                if (pg) begin pend = 1'b1; pc = 0; end
                pg = 1'b0;
                if (pend) begin
                    pc++;
                    if (pc == rv_dly) begin i_dm_rvalid = 1'b1; pend = 1'b0; end
                end
                if (o_dm_req) begin
                    if (rc == gnt_dly) begin i_dm_gnt = 1'b1; pg = 1'b1; end
                    else if (inj && rc == 1) begin i_dm_rvalid = 1'b1; i_dm_rdata = 32'hBAD0BAD0; end
                    rc++;
                end else rc = 0;
            end
        end
    end

    // Monitor: checks bus handshakes and access completions against the scoreboard
    initial begin
        logic        pw, pr, pwe, acc;
        logic [31:0] pa, pd;
        logic [3:0]  ps;
        int          stall, reqrun;
        bus_t        b;
        done_t       d;
        pw = 1'b0; pr = 1'b0; stall = 0; reqrun = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pw = 1'b0; pr = 1'b0; stall = 0; reqrun = 0;
            end else begin
                acc = i_DM_write != 2'd0 || (i_DM_read != 3'd0 && i_DM_read <= 3'd5);
                if (o_dm_req) begin
                    reqrun++;
                    if (pr) begin
                        chk("req_addr_stable", o_dm_addr, pa);
                        chk("req_wdata_stable", o_dm_wdata, pd);
                        chk("req_ctl_stable", {27'd0, o_dm_we, o_dm_wstrb}, {27'd0, pwe, ps});
                    end
                    if (i_dm_gnt) begin
                        nreq++;
                        if (bus_q.size() == 0) begin
                            tests++; fails++;
                            $display("FAIL bus_unexpected: request to %h with none expected", o_dm_addr);
                        end else begin
                            b = bus_q.pop_front();
                            chk("bus_addr", o_dm_addr, b.addr);
                            chk("bus_ctl", {27'd0, o_dm_we, o_dm_wstrb}, {27'd0, b.we, b.wstrb});
                            chk("bus_wdata", o_dm_wdata, b.wdata);
                            chk("bus_req_cycles", reqrun, b.reqc);
                        end
                        reqrun = 0;
                    end
                end else reqrun = 0;
                pr = o_dm_req; pa = o_dm_addr; pd = o_dm_wdata; pwe = o_dm_we; ps = o_dm_wstrb;
                if (acc && !o_wait_DM1 && pw) begin
                    if (done_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL done_unexpected: completion with none expected");
                    end else begin
                        d = done_q.pop_front();
                        chk("load_data", o_load_data, d.ld);
                        chk("misaligned", o_misaligned, d.mis);
                        chk("stall_cycles", stall, d.stall);
                    end
                end else chk("mis_quiet", o_misaligned, 1'b0);
                stall = o_wait_DM1 ? stall + 1 : 0;
                pw = o_wait_DM1;
            end
        end
    end

    task automatic run(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] addr, rs2, rdata,
                       input int gd, rvd, wfi_n, input logic inj_rv,
                       input logic [31:0] e_addr, input logic [3:0] e_strb, input logic [31:0] e_wdata,
                       input logic [31:0] e_ld, input logic e_mis);
        bus_t  b;
        done_t d;
        int    n;
        @(posedge clk);
        #1;
        gnt_dly = gd; rv_dly = rvd; inj = inj_rv; mem_rdata = rdata;
        i_wait_WFI = wfi_n > 0;
        i_DM_read = rd; i_DM_write = wr; i_aluresult = addr; i_rs2_data = rs2;
        if (!e_mis) begin
            b.addr = e_addr; b.we = wr != 2'd0; b.wstrb = e_strb; b.wdata = e_wdata; b.reqc = gd + 1;
            bus_q.push_back(b);
            exp_req++;
        end
        d.ld = e_ld; d.mis = e_mis; d.stall = e_mis ? 1 : 2 + gd + rvd;
        done_q.push_back(d);
        n = 0;
        do begin @(negedge clk); n++; end while (o_wait_DM1 && n < 100);
        if (o_wait_DM1) begin
            tests++; fails++;
            $display("FAIL access_timeout: wait still %b after %0d cycles, want 0", o_wait_DM1, n);
        end
        repeat (wfi_n) @(negedge clk);
        i_wait_WFI = 1'b0;
        @(posedge clk);
        #1;
        i_DM_read = 3'd0; i_DM_write = 2'd0; inj = 1'b0;
    endtask

    initial begin
        bus_t b;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_t b;
        repeat (3) @(negedge clk);
        chk("rst_req", o_dm_req, 1'b0);
        chk("rst_wait", o_wait_DM1, 1'b0);
        chk("rst_addr", o_dm_addr, 32'd0);
        chk("rst_load", o_load_data, 32'd0);
        chk("rst_ctl", {27'd0, o_dm_we, o_dm_wstrb}, 32'd0);
        rst_n = 1'b1;
        //  rd  wr  addr          rs2           rdata         gd rvd wfi inj  e_addr        strb   e_wdata       e_ld          mis
        run(3'd0, 2'd3, 32'h100, 32'hDEADBEEF, 32'h0,        0, 1, 0, 1'b0, 32'h100, 4'hF,  32'hDEADBEEF, 32'h0,        1'b0);
        run(3'd0, 2'd1, 32'h103, 32'h000000A5, 32'h0,        0, 1, 0, 1'b0, 32'h100, 4'h8,  32'hA5A5A5A5, 32'h0,        1'b0);
        run(3'd1, 2'd0, 32'h102, 32'h0,        32'h12803456, 0, 1, 0, 1'b0, 32'h100, 4'h0,  32'h0,        32'hFFFFFF80, 1'b0);
        run(3'd4, 2'd0, 32'h102, 32'h0,        32'h12803456, 0, 1, 0, 1'b0, 32'h100, 4'h0,  32'h0,        32'h00000080, 1'b0);
        run(3'd2, 2'd0, 32'h101, 32'h0,        32'h12803456, 0, 1, 0, 1'b0, 32'h0,   4'h0,  32'h0,        32'h0,        1'b1);
        run(3'd2, 2'd0, 32'h102, 32'h0,        32'h80011234, 0, 1, 0, 1'b0, 32'h100, 4'h0,  32'h0,        32'hFFFF8001, 1'b0);
        run(3'd5, 2'd0, 32'h102, 32'h0,        32'h80011234, 0, 1, 0, 1'b0, 32'h100, 4'h0,  32'h0,        32'h00008001, 1'b0);
        run(3'd0, 2'd2, 32'h102, 32'h1234ABCD, 32'h0,        0, 1, 0, 1'b0, 32'h100, 4'hC,  32'hABCDABCD, 32'h00008001, 1'b0);
        run(3'd3, 2'd0, 32'h108, 32'h0,        32'h13579BDF, 4, 2, 0, 1'b1, 32'h108, 4'h0,  32'h0,        32'h13579BDF, 1'b0);
        run(3'd3, 2'd0, 32'h10C, 32'h0,        32'h55AA1234, 0, 1, 5, 1'b0, 32'h10C, 4'h0,  32'h0,        32'h55AA1234, 1'b0);
        run(3'd3, 2'd3, 32'h110, 32'h11223344, 32'hFFFFFFFF, 0, 1, 0, 1'b0, 32'h110, 4'hF,  32'h11223344, 32'h55AA1234, 1'b0);
        // reserved load code is no access
        @(posedge clk);
        #1;
        i_DM_read = 3'd6;
        repeat (2) begin
            @(negedge clk);
            chk("rd6_wait", o_wait_DM1, 1'b0);
            chk("rd6_req", o_dm_req, 1'b0);
        end
        @(posedge clk);
        #1;
        i_DM_read = 3'd0;
        // reset while waiting for a response
        @(posedge clk);
        #1;
        gnt_dly = 0; rv_dly = 5; mem_rdata = 32'hFFFF0000;
        i_DM_read = 3'd3; i_aluresult = 32'h200;
        b.addr = 32'h200; b.we = 1'b0; b.wstrb = 4'h0; b.wdata = 32'h0; b.reqc = 1;
        bus_q.push_back(b);
        exp_req++;
        repeat (3) @(negedge clk);
        chk("pre_rst_wait", o_wait_DM1, 1'b1);
        #2;
        rst_n = 1'b0;
        i_DM_read = 3'd0;
        #1;
        chk("mid_rst_req", o_dm_req, 1'b0);
        chk("mid_rst_wait", o_wait_DM1, 1'b0);
        chk("mid_rst_addr", o_dm_addr, 32'd0);
        chk("mid_rst_wdata", o_dm_wdata, 32'd0);
        chk("mid_rst_load", o_load_data, 32'd0);
        chk("mid_rst_ctl", {26'd0, o_misaligned, o_dm_we, o_dm_wstrb}, 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        run(3'd3, 2'd0, 32'h204, 32'h0,        32'hCAFEF00D, 0, 1, 0, 1'b0, 32'h204, 4'h0,  32'h0,        32'hCAFEF00D, 1'b0);
        run(3'd3, 2'd0, 32'h106, 32'h0,        32'h77777777, 0, 1, 0, 1'b0, 32'h0,   4'h0,  32'h0,        32'h0,        1'b1);
        repeat (8) @(negedge clk);
        chk("bus_count", nreq, exp_req);
        chk("bus_q_left", bus_q.size(), 32'd0);
        chk("done_q_left", done_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dm_access_unit.md
Name: dm_access_unit

Overview:
- MEM-stage data-memory access controller.
- Consumes the EX/MEM pipeline register outputs (DM_read/DM_write codes, ALU address, rs2 store data) and performs the access on the data-memory request/response port.
- Returns the load result to write-back and drives i_wait_DM1 back into the pipeline registers to freeze the pipeline until the access completes.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width; fixed at 32 (4 byte lanes).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_DM_read  in  3  load code from EX/MEM register.
- i_DM_write  in  2  store code from EX/MEM register.
- i_aluresult  in  32  effective byte address.
- i_rs2_data  in  32  store data, right-justified.
- i_wait_WFI  in  1  pipeline held by WFI; access must not re-issue.
- o_wait_DM1  out  1  stall request to all pipeline registers.
- o_load_data  out  32  aligned, extended load result for WB.
- o_misaligned  out  1  one-cycle pulse on a misaligned access.
- o_dm_req  out  1  memory request valid.
- o_dm_we  out  1  1 = write.
- o_dm_addr  out  32  word address ({addr[31:2],2'b00}).
- o_dm_wstrb  out  4  byte-lane write strobes.
- o_dm_wdata  out  32  lane-replicated store data.
- i_dm_gnt  in  1  request accepted this cycle.
- i_dm_rvalid  in  1  response (read data or write ack) valid.
- i_dm_rdata  in  32  read data.

Behaviour:
- Access codes:
  - DM_read: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU; 6 and 7 are treated as none.
  - DM_write: 0 none, 1 SB, 2 SH, 3 SW.
  - Both nonzero at once: store wins, load is ignored.
- Reset: FSM to IDLE. o_dm_req, o_dm_we, o_dm_wstrb, o_dm_addr, o_dm_wdata, o_load_data and o_misaligned all go to 0. Reset mid-access drops the request; the memory side must discard any outstanding response.
- FSM states: IDLE, REQ, RESP, DONE.
  - IDLE, access present and aligned -> REQ. Request fields are registered this cycle.
  - IDLE, access present and misaligned -> DONE, with o_misaligned pulsed and o_load_data = 0. No bus request is made.
  - REQ: o_dm_req held high with stable fields until i_dm_gnt. On gnt -> RESP and o_dm_req drops next cycle.
  - RESP: on i_dm_rvalid -> DONE. For a load, o_load_data is captured this edge.
  - DONE: if !i_wait_WFI -> IDLE (pipeline advances this edge). Otherwise stay in DONE; no re-issue while WFI holds.
- o_wait_DM1 (combinational):
  - High when (IDLE and access present) or in REQ or in RESP.
  - Low in DONE and when idle with no access.
- Minimum stall for an aligned access (gnt and rvalid each one cycle after the request): 3 cycles. Cycle 0 IDLE, cycle 1 REQ with gnt, cycle 2 RESP with rvalid, cycle 3 DONE with wait low.
- i_dm_rvalid is ignored outside RESP. i_dm_gnt is ignored outside REQ.
- Misalignment rules:
  - LH/LHU/SH: addr[0] = 1 is misaligned.
  - LW/SW: addr[1:0] != 0 is misaligned.
  - Byte accesses are never misaligned.
- Store lanes, with off = addr[1:0]:
  - SB: wstrb = 1 << off, wdata = {4{rs2[7:0]}}.
  - SH: wstrb = 4'b0011 << off, wdata = {2{rs2[15:0]}}.
  - SW: wstrb = 4'hF, wdata = rs2.
- Load extract: shifted = rdata >> (8*off).
  - LB/LH: sign-extend shifted[7:0] / shifted[15:0].
  - LBU/LHU: zero-extend.
  - LW: rdata unchanged.
- o_load_data holds its value until the next load completes. Stores do not change it.

Decomposition:
- Package dm_pkg:
  - typedef enum for DM_read codes (DM_RD_NONE, LB, LH, LW, LBU, LHU).
  - typedef enum for DM_write codes (DM_WR_NONE, SB, SH, SW).
  - FSM state enum.
- Sub-module dm_lane_align: purely combinational.
  - Store path: wstrb/wdata generation.
  - Load path: shift and extend.
  - Misalignment detect.
- The top module holds the FSM and registers.

Test Plan:
- SW addr 0x100, rs2 0xDEADBEEF; gnt and rvalid each one cycle later -> o_dm_addr 0x100, wstrb 4'hF, wdata 0xDEADBEEF; o_wait_DM1 high exactly 3 cycles; o_dm_req high 1 cycle.
- SB addr 0x103, rs2 0x000000A5 -> wstrb 4'b1000, wdata 0xA5A5A5A5.
- LB addr 0x102, rdata 0x12_80_34_56 -> o_load_data 0xFFFFFF80. Same access as LBU -> 0x00000080.
- LH addr 0x101 -> o_misaligned pulses 1 cycle, no o_dm_req, o_wait_DM1 high only the IDLE cycle, o_load_data 0.
- gnt held off 4 cycles, then rvalid 2 cycles after gnt -> req stable throughout, wait high until the DONE cycle; an rvalid injected during REQ is ignored.
- i_wait_WFI high on completion for 5 cycles -> stays DONE, exactly one bus request. Separately, rst_n low during RESP -> all outputs 0 and next access proceeds normally.
